// File: rtl/clb_lut_pkg.sv
// Shared definitions for the fracturable LUT chain: load FSM states and
// helpers that derive frame/fracture geometry from the LUT parameters.
package clb_lut_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } load_state_e;

    // Total serial configuration bits: truth table plus split bit per stage.
    function automatic int frame_bits(input int inputs, input int stages);
        return stages * ((2 ** inputs) + 1);
    endfunction

    // Number of sub-LUTs a stage is fractured into.
    function automatic int sub_luts(input int fracturing);
        return 2 ** (fracturing - 1);
    endfunction

    // Address bits seen by each sub-LUT.
    function automatic int seg_width(input int inputs, input int fracturing);
        return inputs - fracturing + 1;
    endfunction

    // Truth-table bits owned by each sub-LUT.
    function automatic int seg_size(input int inputs, input int fracturing);
        return 2 ** seg_width(inputs, fracturing);
    endfunction

endpackage

// File: rtl/lut_frac_stage.sv
// One fracturable LUT stage: purely combinational lookup of a MEM_SIZE-bit
// truth table, giving the full output plus SUB independent sub-LUT outputs.
module lut_frac_stage
    import clb_lut_pkg::*;
#(
    parameter  int INPUTS     = 4,
    parameter  int FRACTURING = 2,
    localparam int MEM_SIZE   = 2 ** INPUTS,
    localparam int SUB        = sub_luts(FRACTURING)
) (
    input  logic [MEM_SIZE-1:0] mem_i,
    input  logic [INPUTS-1:0]   addr_i,
    output logic [SUB-1:0]      sub_o,
    output logic                full_o
);

    localparam int W   = seg_width(INPUTS, FRACTURING);
    localparam int SEG = seg_size(INPUTS, FRACTURING);

    // Full output looks up the whole table with every address bit.
    assign full_o = mem_i[addr_i];

    // Sub-LUT i owns table segment i and sees only the low W address bits.
    for (genvar i = 0; i < SUB; i++) begin : g_sub
        logic [INPUTS-1:0] idx;
        assign idx      = INPUTS'(i * SEG) + INPUTS'(addr_i[W-1:0]);
        assign sub_o[i] = mem_i[idx];
    end

endmodule

// File: rtl/lut_sxx_frac_chain.sv
// Chain of STAGES fracturable LUT stages with a serial, atomically committed
// configuration frame. Each stage k>0 takes its top address bit either from
// the previous stage's full output (chained) or from addr (split).
// Optional feature macro: LUT_OUT_REG_EN registers every out bit on clk.
module lut_sxx_frac_chain
    import clb_lut_pkg::*;
#(
    parameter  int INPUTS     = 4,
    parameter  int FRACTURING = 2,
    parameter  int STAGES     = 2,
    localparam int MEM_SIZE   = 2 ** INPUTS,
    localparam int SUB        = sub_luts(FRACTURING)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [STAGES*INPUTS-1:0]     addr,
    output logic [STAGES*(SUB+1)-1:0]    out,
    input  logic                         config_en,
    input  logic                         config_in,
    output logic                         config_ready,
    output logic                         cfg_done
);

    localparam int FRAME  = frame_bits(INPUTS, STAGES);
    localparam int STRIDE = MEM_SIZE + 1;
    localparam int CNT_W  = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    load_state_e                 state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [FRAME-1:0]            shadow_q, shadow_d;
    logic [FRAME-1:0]            active_q, active_d;
    logic                        accept;
    logic [STAGES*(SUB+1)-1:0]   out_d;

    // The loader only stalls for the single commit cycle.
    assign config_ready = (state_q != COMMIT);
    assign cfg_done     = (state_q == COMMIT);
    assign accept       = config_en & config_ready;

    // Load FSM: shift bits into the shadow frame, then copy it to active.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        unique case (state_q)
            IDLE, LOAD: begin
                // IDLE always sits at counter 0, so both states share one path.
                if (accept) begin
                    shadow_d[cnt_q] = config_in;
                    if (cnt_q == LAST) begin
                        state_d = COMMIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                active_d = shadow_q;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Loader and frame registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            // NOTE: the frames are flops, not a RAM; clearing them gives
            // all-zero tables and chained mode straight out of reset.
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Stage lookups; the chain from stage k-1 to stage k is combinational.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [INPUTS-1:0]   stage_addr;
        logic [MEM_SIZE-1:0] mem;
        logic [SUB-1:0]      sub;
        logic                full;

        assign mem = active_q[k*STRIDE +: MEM_SIZE];

        if (k == 0) begin : g_first
            // Stage 0 has no predecessor, so its split bit is stored but unused.
            logic unused_split0;
            assign unused_split0 = active_q[MEM_SIZE];
            assign stage_addr    = addr[INPUTS-1:0];
        end else begin : g_next
            logic top;
            assign top        = active_q[k*STRIDE + MEM_SIZE]
                              ? addr[k*INPUTS + INPUTS - 1]
                              : g_stage[k-1].full;
            assign stage_addr = {top, addr[k*INPUTS +: INPUTS-1]};
        end

        lut_frac_stage #(
            .INPUTS     (INPUTS),
            .FRACTURING (FRACTURING)
        ) u_stage (
            .mem_i  (mem),
            .addr_i (stage_addr),
            .sub_o  (sub),
            .full_o (full)
        );

        assign out_d[k*(SUB+1) +: SUB+1] = {full, sub};
    end

`ifdef LUT_OUT_REG_EN
    // Registered port: one cycle after addr or commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out_d;
        end
    end
`else
    assign out = out_d;
`endif

endmodule

// File: tb/tb_lut_sxx_frac_chain.sv
// Directed bench for lut_sxx_frac_chain (INPUTS=4, FRACTURING=2, STAGES=2).
// Expected outputs come from an independent behavioural model, queued as
// stimulus is driven and popped when the output is sampled.
module tb_lut_sxx_frac_chain;

    localparam int FRAME = 34;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] addr;
    logic [5:0] out;
    logic       config_en;
    logic       config_in;
    logic       config_ready;
    logic       cfg_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [5:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    always #5 clk = ~clk;

    lut_sxx_frac_chain #(
        .INPUTS     (4),
        .FRACTURING (2),
        .STAGES     (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr         (addr),
        .out          (out),
        .config_en    (config_en),
        .config_in    (config_in),
        .config_ready (config_ready),
        .cfg_done     (cfg_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Frame layout: {split1, mem1, split0, mem0}, loaded LSB first.
    function automatic logic [33:0] mk_frame(input logic [15:0] m0, input logic s0,
                                             input logic [15:0] m1, input logic s1);
        return {s1, m1, s0, m0};
    endfunction

    // Behavioural reference: out = {full1, sub1[1:0], full0, sub0[1:0]}.
    function automatic logic [5:0] model(input logic [33:0] f, input logic [7:0] a);
        logic [15:0] m0;
        logic [15:0] m1;
        int a0, a1, top;
        logic f0, f1;
        m0  = f[15:0];
        m1  = f[32:17];
        a0  = int'(a[3:0]);
        f0  = m0[a0];
        top = f[33] ? int'(a[7]) : int'(f0);
        a1  = top * 8 + int'(a[6:4]);
        f1  = m1[a1];
        return {f1, m1[8 + (a1 % 8)], m1[a1 % 8], f0, m0[8 + (a0 % 8)], m0[a0 % 8]};
    endfunction

    task automatic expect_out(input string tag, input logic [5:0] exp);
        sb_q.push_back('{tag, exp});
    endtask

    task automatic compare_out();
        sb_item_t item;
        if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            item = sb_q.pop_front();
            check(item.tag, 32'(out), 32'(item.exp));
        end
    endtask

    // One loader cycle outside COMMIT: ready high, no done, old outputs.
    task automatic cycle_load(input string tag, input logic [5:0] exp_out);
        expect_out({tag, "_out"}, exp_out);
        @(negedge clk);
        check({tag, "_done"}, 32'(cfg_done), 32'd0);
        check({tag, "_ready"}, 32'(config_ready), 32'd1);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    // Serial load of a whole frame with optional pause, then commit checks.
    task automatic load_frame(input string tag, input logic [33:0] f,
                              input logic [33:0] old_f, input int pause_at,
                              input int pause_len, input logic en_in_commit);
        for (int n = 0; n < FRAME; n++) begin
            if (n == pause_at) begin
                for (int p = 0; p < pause_len; p++) begin
                    config_en = 1'b0;
                    config_in = 1'($urandom);
                    cycle_load({tag, "_pause"}, model(old_f, addr));
                end
            end
            config_en = 1'b1;
            config_in = f[n];
            cycle_load(tag, model(old_f, addr));
        end
        config_en = en_in_commit;
        config_in = 1'b1;
        expect_out({tag, "_commit_out"}, model(old_f, addr));
        @(negedge clk);
        check({tag, "_commit_done"}, 32'(cfg_done), 32'd1);
        check({tag, "_commit_ready"}, 32'(config_ready), 32'd0);
        compare_out();
        @(posedge clk);
        #1;
        config_en = 1'b0;
        expect_out({tag, "_new_out"}, model(f, addr));
        @(negedge clk);
        check({tag, "_post_done"}, 32'(cfg_done), 32'd0);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string tag, input logic [7:0] a, input logic [33:0] f);
        addr = a;
        expect_out(tag, model(f, a));
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] f_zero, f_chain, f_split, f_pause, f_c5, f_c6;
        f_zero  = '0;
        f_chain = mk_frame(16'hAAAA, 1'b0, 16'hFF00, 1'b0);
        f_split = mk_frame(16'hAAAA, 1'b0, 16'hFF00, 1'b1);
        f_pause = mk_frame(16'h1234, 1'b0, 16'h8001, 1'b0);
        f_c5    = mk_frame(16'h0F0F, 1'b1, 16'h3C3C, 1'b0);
        f_c6    = mk_frame(16'hC3A5, 1'b0, 16'h5A96, 1'b1);

        // Reset with arbitrary address.
        rst_n     = 1'b0;
        config_en = 1'b0;
        config_in = 1'b0;
        addr      = 8'h5A;
        #3;
        check("reset_out", 32'(out), 32'd0);
        check("reset_ready", 32'(config_ready), 32'd1);
        check("reset_done", 32'(cfg_done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Chained load; commit at cycle 34.
        addr = 8'h01;
        load_frame("chain", f_chain, f_zero, -1, 0, 1'b0);
        probe("chain_a01", 8'h01, f_chain);
        check("chain_a01_full1", 32'(out[5]), 32'd1);
        probe("chain_a00", 8'h00, f_chain);
        check("chain_a00_full1", 32'(out[5]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            probe("chain_rand", 8'($urandom), f_chain);
        end

        // Split mode: stage-1 top bit from addr[7].
        load_frame("split", f_split, f_chain, -1, 0, 1'b0);
        probe("split_a81", 8'h81, f_split);
        check("split_a81_full1", 32'(out[5]), 32'd1);
        probe("split_a01", 8'h01, f_split);
        check("split_a01_full1", 32'(out[5]), 32'd0);

        // Pause of 5 cycles after bit 10: commit at cycle 39, new out at 40.
        addr = 8'h37;
        load_frame("pause", f_pause, f_split, 11, 5, 1'b0);
        probe("pause_aE6", 8'hE6, f_pause);

        // Bit offered during COMMIT is dropped; next frame starts at shadow[0].
        addr = 8'hB3;
        load_frame("commit_en", f_c5, f_pause, -1, 0, 1'b1);
        load_frame("after_drop", f_c6, f_c5, -1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            probe("after_drop_rand", 8'($urandom), f_c6);
        end

        // Reset at bit 20 of a load loses the partial frame and the active one.
        addr = 8'h9C;
        for (int n = 0; n < 20; n++) begin
            config_en = 1'b1;
            config_in = f_chain[n];
            cycle_load("partial", model(f_c6, addr));
        end
        rst_n = 1'b0;
        #1;
        check("midreset_out", 32'(out), 32'd0);
        check("midreset_ready", 32'(config_ready), 32'd1);
        check("midreset_done", 32'(cfg_done), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        config_en = 1'b0;
        addr      = 8'h81;
        load_frame("reload", f_split, f_zero, -1, 0, 1'b0);
        probe("reload_a81", 8'h81, f_split);
        check("reload_a81_full1", 32'(out[5]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lut_sxx_frac_chain.md
# lut_sxx_frac_chain

Parametrised, runtime-configurable chain of fracturable LUT stages for the CLB. It generalises the two-LUT S_XX slice to `STAGES` stages. Each stage's top address bit is selected per stage, by a configuration bit, from either the previous stage's full output (chained) or an external address bit (split). Configuration is loaded serially through a counted load FSM into a shadow frame and committed atomically, so logic outputs never observe a partially loaded frame.

## Interface
Parameters:
- `INPUTS`, 4: address bits per stage (≥2).
- `FRACTURING`, 2: fracture level (1..INPUTS-1); SUB = 2^(FRACTURING-1) sub-LUTs per stage.
- `STAGES`, 2: number of chained stages (≥1).
- `MEM_SIZE`, 2**INPUTS: truth-table bits per stage (derived, not overridden).

Ports:
- `clk`  in  1  single clock; config and output logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addr`  in  STAGES*INPUTS  LUT address inputs; stage k uses `addr[k*INPUTS +: INPUTS]`.
- `out`  out  STAGES*(SUB+1)  stage k at `[k*(SUB+1) +: SUB+1]`: bits `[SUB-1:0]` are sub-LUT outputs, bit `[SUB]` is the full output.
- `config_en`  in  1  valid for `config_in`; one bit accepted per cycle when `config_ready` is high.
- `config_in`  in  1  serial configuration bit.
- `config_ready`  out  1  high when the loader accepts a bit.
- `cfg_done`  out  1  one-cycle pulse when a frame commits.

## Operation
- Frame: FRAME = STAGES*(MEM_SIZE+1) bits. Stage k occupies `[k*(MEM_SIZE+1) +: MEM_SIZE+1]`: bits `[MEM_SIZE-1:0]` are the truth table, bit `[MEM_SIZE]` is `split[k]`. The stage-0 split bit is stored and ignored.
- Bits are loaded LSB-first: the n-th accepted bit goes to shadow bit n.
- Stage addressing: stage 0 uses `addr[INPUTS-1:0]`. Stage k>0 uses `{top_k, addr[k*INPUTS +: INPUTS-1]}`, with `top_k = split[k] ? addr[k*INPUTS+INPUTS-1] : full[k-1]`.
- Full output: `mem_k[stage_addr]`.
- Sub-LUT i (0..SUB-1): `mem_k[i*SEG + stage_addr[W-1:0]]`, with W = INPUTS-FRACTURING+1 and SEG = 2^W.
- FSM states:
  - IDLE: counter 0. An accepted bit writes shadow[0], counter becomes 1, state goes to LOAD. If FRAME==1, state goes directly to COMMIT.
  - LOAD: an accepted bit writes shadow[counter] and increments the counter. The accepted bit at counter == FRAME-1 moves the state to COMMIT. `config_en` low pauses the load: counter and shadow hold, with no timeout.
  - COMMIT: `config_ready`=0 and `config_en` is ignored (the bit is dropped). Shadow is copied to active, `cfg_done`=1 for this cycle, counter clears, state returns to IDLE.
- Active configuration changes only in COMMIT; outputs use the previous frame throughout LOAD.
- Reset mid-load: state IDLE, counter 0, shadow and active cleared. The partial frame is lost.

## Timing
- Reset values:
  - `out`=0 (all-zero tables).
  - `config_ready`=1.
  - `cfg_done`=0.
  - Active and shadow frames all zero; `split`=0 (chained).
- An uninterrupted load of FRAME bits starting at cycle 0 gives `cfg_done` high in cycle FRAME (the COMMIT cycle). The new configuration drives `out` from cycle FRAME+1.
- `config_ready` is combinational from state (low only in COMMIT).
- Without `LUT_OUT_REG_EN`, `out` is combinational from `addr` and active config; chain depth is STAGES lookups.

## Configuration
- `LUT_OUT_REG_EN` defined: every `out` bit is registered on `clk`, reset to 0. Latency is 1 cycle from `addr` and from commit. The internal chain (`full[k-1]` → stage k) stays combinational; only the port is registered.
- Undefined: `out` is purely combinational; no output flops.

## Structure
- Shared package `clb_lut_pkg`:
  - Load FSM state enum (IDLE, LOAD, COMMIT).
  - Helper functions for FRAME, SUB, SEG and W.
- Sub-module `lut_frac_stage`: one stage's combinational lookup (MEM_SIZE-bit table, INPUTS address bits) producing SUB sub-outputs plus the full output. It is instantiated STAGES times via generate.
- Loader FSM, counter and shadow/active registers live in the top module.

## Test plan
All scenarios use INPUTS=4, FRACTURING=2, STAGES=2 (FRAME=34, SUB=2, SEG=8, `out` width 6).
- Reset: assert `rst_n`=0 with arbitrary `addr` → `out`=6'b0, `config_ready`=1, `cfg_done`=0.
- Chained load: mem0=16'hAAAA, split0=0, mem1=16'hFF00, split1=0, loaded in 34 consecutive cycles → `cfg_done` pulses at cycle 34 only. Then for `addr`=8'h01: full0=1, stage-1 top bit=1 → full1=1. For `addr`=8'h00: full0=0 → full1=0.
- Split mode: same tables with split1=1. `addr`=8'h81 → full1=1 (from `addr[7]`). `addr`=8'h01 → full1=0.
- Pause: drop `config_en` for 5 cycles after bit 10 → `cfg_done` at cycle 39. `out` keeps the old configuration until cycle 40.
- `config_en` high during COMMIT → that bit is ignored. The next accepted bit starts a new frame at shadow[0]. `config_ready`=0 during COMMIT only.
- Reset at bit 20 of a load after a prior commit → `out`=0. A following complete 34-bit load commits normally at cycle 34.
